// File: rtl/cardio_tnn1_seqctl.sv
// Sequencing controller for the cardio TNN classifier: loads a feature vector beat by beat,
// waits for the combinational classifier to settle, captures the prediction and keeps class statistics.
module cardio_tnn1_seqctl #(
    parameter int FEAT_CNT      = 19,
    parameter int FEAT_BITS     = 4,
    parameter int CLASS_CNT     = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_BITS      = 16,
    localparam int PRED_W       = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          feat_valid,
    input  logic [FEAT_BITS-1:0]          feat_data,
    output logic                          feat_ready,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [PRED_W-1:0]             prediction,
    output logic                          out_valid,
    output logic [PRED_W-1:0]             out_pred,
    input  logic                          out_ready,
    input  logic                          clr_counts,
    output logic [CLASS_CNT*CNT_BITS-1:0] class_count,
    output logic [CNT_BITS-1:0]           n_done,
    output logic                          pred_err
);

    localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PRED_W:0] CLASS_LIM = (PRED_W+1)'(CLASS_CNT);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [SET_W-1:0]   settle_reg, settle_next;
    logic               out_valid_reg, out_valid_next;
    logic [PRED_W-1:0]  out_pred_reg, out_pred_next;
    logic               beat_accept;
    logic               capture;
    logic               pred_ok;

    assign feat_ready  = (state_reg == ST_LOAD) && !rst;
    assign beat_accept = feat_valid && feat_ready;
    assign pred_ok     = {1'b0, prediction} < CLASS_LIM;
    assign out_valid   = out_valid_reg;
    assign out_pred    = out_pred_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            idx_reg       <= '0;
            settle_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_pred_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            settle_reg    <= settle_next;
            out_valid_reg <= out_valid_next;
            out_pred_reg  <= out_pred_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        settle_next    = settle_reg;
        out_valid_next = out_valid_reg;
        out_pred_next  = out_pred_reg;
        capture        = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                if (beat_accept) begin
                    if (idx_reg == IDX_W'(FEAT_CNT-1)) begin
                        idx_next    = '0;
                        settle_next = SET_W'(SETTLE_CYCLES-1);
                        state_next  = ST_SETTLE;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                // Counter reaching zero marks the edge where the classifier output is trusted.
                if (settle_reg == '0) begin
                    capture        = 1'b1;
                    out_pred_next  = prediction;
                    out_valid_next = 1'b1;
                    state_next     = ST_OUT;
                end else begin
                    settle_next = settle_reg - SET_W'(1);
                end
            end
            ST_OUT: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // One register per feature slot; only the slot addressed by idx is written.
    generate
        for (genvar gi = 0; gi < FEAT_CNT; gi++) begin : g_slot
            logic [FEAT_BITS-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (beat_accept && (idx_reg == IDX_W'(gi))) begin
                    slot_reg <= feat_data;
                end
            end
            assign features[gi*FEAT_BITS +: FEAT_BITS] = slot_reg;
        end
    endgenerate

    // Clear has priority over a simultaneous capture increment.
    generate
        for (genvar gi = 0; gi < CLASS_CNT; gi++) begin : g_cls
            logic [CNT_BITS-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || clr_counts) begin
                    cnt_reg <= '0;
                end else if (capture && pred_ok && (prediction == PRED_W'(gi))
                             && (cnt_reg != {CNT_BITS{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_BITS'(1);
                end
            end
            assign class_count[gi*CNT_BITS +: CNT_BITS] = cnt_reg;
        end
    endgenerate

    logic [CNT_BITS-1:0] n_done_reg;
    logic                pred_err_reg;

    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            n_done_reg   <= '0;
            pred_err_reg <= 1'b0;
        end else if (capture) begin
            if (n_done_reg != {CNT_BITS{1'b1}}) begin
                n_done_reg <= n_done_reg + CNT_BITS'(1);
            end
            if (!pred_ok) begin
                pred_err_reg <= 1'b1;
            end
        end
    end

    assign n_done   = n_done_reg;
    assign pred_err = pred_err_reg;

endmodule

// File: tb/tb_cardio_tnn1_seqctl.sv
// Randomized bench for cardio_tnn1_seqctl with a transaction-level reference model;
// a second instance with 2-bit counters exposes saturation.
module tb_cardio_tnn1_seqctl;

    localparam int FC  = 19;
    localparam int FB  = 4;
    localparam int NC  = 3;
    localparam int SC  = 2;
    localparam int CB  = 16;
    localparam int CBS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, feat_valid, out_ready, clr_counts;
    logic [FB-1:0] feat_data;
    logic [1:0]    prediction;

    logic             feat_ready, out_valid, pred_err;
    logic [FC*FB-1:0] features;
    logic [1:0]       out_pred;
    logic [NC*CB-1:0] class_count;
    logic [CB-1:0]    n_done;

    logic              s_feat_ready, s_out_valid, s_pred_err;
    logic [FC*FB-1:0]  s_features;
    logic [1:0]        s_out_pred;
    logic [NC*CBS-1:0] s_class_count;
    logic [CBS-1:0]    s_n_done;

    cardio_tnn1_seqctl #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(NC),
                         .SETTLE_CYCLES(SC), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(feat_ready), .features(features), .prediction(prediction),
        .out_valid(out_valid), .out_pred(out_pred), .out_ready(out_ready),
        .clr_counts(clr_counts), .class_count(class_count), .n_done(n_done),
        .pred_err(pred_err));

    cardio_tnn1_seqctl #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(NC),
                         .SETTLE_CYCLES(SC), .CNT_BITS(CBS)) dut_s (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(s_feat_ready), .features(s_features), .prediction(prediction),
        .out_valid(s_out_valid), .out_pred(s_out_pred), .out_ready(out_ready),
        .clr_counts(clr_counts), .class_count(s_class_count), .n_done(s_n_done),
        .pred_err(s_pred_err));

    int total = 0;
    int bad   = 0;

    // Reference model: the expected vector contents and unsaturated event counts.
    logic [FB-1:0] exp_feat [FC];
    logic [FB-1:0] vec [FC];
    int            raw_cnt [NC];
    int            raw_done;
    bit            exp_err;

    function automatic logic [FC*FB-1:0] pack_feat();
        logic [FC*FB-1:0] v;
        for (int i = 0; i < FC; i++) v[i*FB +: FB] = exp_feat[i];
        return v;
    endfunction

    function automatic int sat(input int v, input int bits);
        int mx;
        mx = (1 << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [1:0] rand_pred();
        if ($urandom_range(7, 0) == 0) return 2'd3;
        return 2'($urandom_range(2, 0));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) raw_cnt[c] = 0;
        raw_done = 0;
        exp_err  = 1'b0;
    endtask

    task automatic check_counts();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("class_count[%0d]", c), 128'(class_count[c*CB +: CB]), 128'(raw_cnt[c]));
            chk($sformatf("sat_class_count[%0d]", c), 128'(s_class_count[c*CBS +: CBS]),
                128'(sat(raw_cnt[c], CBS)));
        end
        chk("n_done", 128'(n_done), 128'(raw_done));
        chk("sat_n_done", 128'(s_n_done), 128'(sat(raw_done, CBS)));
        chk("pred_err", 128'(pred_err), 128'(exp_err));
        chk("sat_pred_err", 128'(s_pred_err), 128'(exp_err));
    endtask

    task automatic load_beats(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                feat_valid = 1'b0;
                feat_data  = 4'($urandom);
                tick();
            end
            feat_valid = 1'b1;
            feat_data  = vec[i];
            #1;
            chk("feat_ready_load", 128'(feat_ready), 128'(1));
            tick();
            exp_feat[i] = vec[i];
            chk("features_load", 128'(features), 128'(pack_feat()));
        end
        feat_valid = 1'b0;
    endtask

    // Settle, capture, optional backpressure, then release; force_pred < 0 means random.
    task automatic finish_vector(input bit clr_cap, input int hold, input int force_pred);
        logic [1:0] p;
        p = '0;
        out_ready = 1'b0;
        for (int k = 1; k <= SC; k++) begin
            p = (force_pred < 0) ? rand_pred() : 2'(force_pred);
            prediction = p;
            feat_valid = 1'($urandom);
            feat_data  = 4'($urandom);
            if (k == SC && clr_cap) clr_counts = 1'b1;
            #1;
            chk("feat_ready_settle", 128'(feat_ready), 128'(0));
            tick();
            clr_counts = 1'b0;
            if (k < SC) begin
                chk("out_valid_early", 128'(out_valid), 128'(0));
            end else begin
                chk("out_valid_rise", 128'(out_valid), 128'(1));
                chk("out_pred", 128'(out_pred), 128'(p));
            end
            chk("features_frozen", 128'(features), 128'(pack_feat()));
        end
        if (clr_cap) begin
            model_clear();
        end else begin
            raw_done++;
            if (p < 2'(NC)) raw_cnt[p]++;
            else exp_err = 1'b1;
        end
        check_counts();
        for (int h = 0; h < hold; h++) begin
            feat_valid = 1'b1;
            feat_data  = 4'($urandom);
            prediction = 2'($urandom);
            #1;
            chk("feat_ready_hold", 128'(feat_ready), 128'(0));
            tick();
            chk("out_valid_hold", 128'(out_valid), 128'(1));
            chk("out_pred_hold", 128'(out_pred), 128'(p));
            chk("features_hold", 128'(features), 128'(pack_feat()));
        end
        feat_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_fall", 128'(out_valid), 128'(0));
        chk("feat_ready_after", 128'(feat_ready), 128'(1));
    endtask

    task automatic rand_vec();
        for (int i = 0; i < FC; i++) vec[i] = 4'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; feat_valid = 1'b1; out_ready = 1'b0; clr_counts = 1'b0;
        feat_data = '0; prediction = '0;
        for (int i = 0; i < FC; i++) exp_feat[i] = '0;
        model_clear();

        tick();
        chk("feat_ready_in_rst", 128'(feat_ready), 128'(0));
        tick();
        chk("feat_ready_in_rst2", 128'(feat_ready), 128'(0));
        chk("out_valid_rst", 128'(out_valid), 128'(0));
        chk("features_rst", 128'(features), 128'(0));
        check_counts();
        rst = 1'b0; feat_valid = 1'b0;
        #1;
        chk("feat_ready_post_rst", 128'(feat_ready), 128'(1));

        // Directed vector of nibbles i mod 16.
        for (int i = 0; i < FC; i++) vec[i] = 4'(i % 16);
        load_beats(FC, 0);
        chk("features_directed", 128'(features), 128'(76'h210FEDCBA9876543210));
        finish_vector(1'b0, 5, 1);

        // Random vectors with idle gaps and random backpressure.
        for (int v = 0; v < 30; v++) begin
            rand_vec();
            load_beats(FC, 2);
            finish_vector(1'b0, $urandom_range(3, 0), -1);
        end

        // Clear while idle, then saturation of the small instance on class 1.
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        model_clear();
        check_counts();
        for (int v = 0; v < 5; v++) begin
            rand_vec();
            load_beats(FC, 0);
            finish_vector(1'b0, 0, 1);
        end
        chk("sat_class1_directed", 128'(s_class_count[1*CBS +: CBS]), 128'(3));
        rand_vec();
        load_beats(FC, 0);
        finish_vector(1'b0, 0, 3);

        // Clear coinciding with a capture edge drops that increment.
        rand_vec();
        load_beats(FC, 1);
        finish_vector(1'b1, 1, 2);
        chk("n_done_after_clr_cap", 128'(n_done), 128'(0));

        // Reset in the middle of a load aborts it and clears everything.
        rand_vec();
        load_beats(7, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < FC; i++) exp_feat[i] = '0;
        model_clear();
        chk("features_mid_rst", 128'(features), 128'(0));
        chk("out_valid_mid_rst", 128'(out_valid), 128'(0));
        check_counts();
        rand_vec();
        load_beats(FC, 0);
        finish_vector(1'b0, 2, -1);

        for (int v = 0; v < 10; v++) begin
            rand_vec();
            load_beats(FC, 1);
            finish_vector(1'b0, $urandom_range(2, 0), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
